// File: rtl/regfile_pkg.sv
// Shared register-file constants and write-controller state type.
// Used by the register file, writeback stage and write controller.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 1 << ADDR_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rfc_state_t;

endpackage

// File: rtl/wb_arbiter2.sv
// Two-input writeback arbiter: A has priority unless B was refused
// on its previous request, which bounds B's wait to one cycle.
module wb_arbiter2 (
    input  logic a_req,
    input  logic b_req,
    input  logic b_starved,
    output logic a_gnt,
    output logic b_gnt
);

    assign b_gnt = b_req & (b_starved | ~a_req);
    assign a_gnt = a_req & ~b_gnt;

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port owner: zero-clears all registers after reset
// or soft clear, then arbitrates ALU and load-unit writeback.
module regfile_write_ctrl #(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int NREGS  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_gnt,
    output logic              rf_write_signal,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              init_busy
);

    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREGS - 1);

    rfc_state_t        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              b_starved;
    logic              run;

    assign run = (state == RUN);

    // Requests are masked while clearing so no grant can leak out.
    wb_arbiter2 u_arb (
        .a_req     (a_req & run),
        .b_req     (b_req & run),
        .b_starved (b_starved),
        .a_gnt     (a_gnt),
        .b_gnt     (b_gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            clr_cnt   <= '0;
            b_starved <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    if (clr_cnt == LAST_REG) begin
                        clr_cnt <= '0;
                        state   <= RUN;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                RUN: begin
                    if (b_gnt) begin
                        b_starved <= 1'b0;
                    end else if (b_req) begin
                        b_starved <= 1'b1;
                    end
                    if (clr_req) begin
                        state   <= INIT;
                        clr_cnt <= '0;
                    end
                end
                default: begin
                    state   <= INIT;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        rf_write_signal = 1'b0;
        rf_write_reg    = '0;
        rf_write_data   = '0;
        init_busy       = 1'b1;
        if (!run) begin
            rf_write_signal = rst;
            rf_write_reg    = clr_cnt;
        end else begin
            init_busy = 1'b0;
            // x0 writes are acknowledged but never reach the file.
            unique case (1'b1)
                a_gnt: begin
                    rf_write_signal = (a_addr != '0);
                    rf_write_reg    = a_addr;
                    rf_write_data   = a_data;
                end
                b_gnt: begin
                    rf_write_signal = (b_addr != '0);
                    rf_write_reg    = b_addr;
                    rf_write_data   = b_data;
                end
                default: begin
                    rf_write_signal = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

- Owns the single write port of the 32 x 32-bit register file.
- After reset, and on a soft-clear request, it sequences a zero-clear of all 32 registers. The register file has no reset of its own.
- During normal operation it arbitrates that port between two writeback requesters: the ALU (A) and the load unit (B).
- It sits between the writeback stage and the register file, and stalls the core while clearing.

## Interface
Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, data width
- NREGS, 32, number of registers cleared (2**ADDR_W)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- clr_req  in  1  soft-clear request; single-cycle pulse, sampled in RUN only
- a_req  in  1  ALU writeback request
- a_addr  in  ADDR_W  ALU destination register (rd)
- a_data  in  DATA_W  ALU result
- a_gnt  out  1  ALU write accepted this cycle
- b_req  in  1  load-unit writeback request
- b_addr  in  ADDR_W  load destination register
- b_data  in  DATA_W  load data
- b_gnt  out  1  load write accepted this cycle
- rf_write_signal  out  1  register-file write enable
- rf_write_reg  out  ADDR_W  register-file write address
- rf_write_data  out  DATA_W  register-file write data
- init_busy  out  1  clear in progress; core must stall

## Operation
- State machine has two states, INIT and RUN. It enters INIT on reset.
- INIT behaviour:
  - 5-bit counter clr_cnt drives the write port: rf_write_signal=1, rf_write_reg=clr_cnt, rf_write_data=0. init_busy=1.
  - clr_cnt increments on each edge.
  - On the edge where clr_cnt==NREGS-1: clr_cnt wraps to 0 and the state goes to RUN.
  - a_gnt=b_gnt=0 throughout INIT.
- RUN, grants:
  - init_busy=0.
  - a_gnt and b_gnt are combinational from the requests and the priority flag. At most one grant is high per cycle.
  - Only A requesting: A granted. Only B requesting: B granted.
  - Both requesting: A wins, unless b_starved=1, in which case B wins.
- RUN, b_starved flag:
  - Set on an edge where b_req=1 and b_gnt=0.
  - Cleared on an edge where b_gnt=1.
  - Guarantees B waits at most one cycle under sustained contention.
- RUN, write port:
  - Driven from the granted requester's addr/data.
  - rf_write_signal = grant & (addr != 0). A write to x0 is granted (acknowledged) but suppressed.
  - No grant: rf_write_signal=0; rf_write_reg and rf_write_data are 0.
- Handshake:
  - A requester holds req, addr and data stable until it sees gnt.
  - The write commits at the rising edge of the gnt cycle.
  - A requester may drop req without a grant only when flushed.
- Same rd from A and B in one cycle: A writes first, B writes on the following grant cycle; B's value is final.
- clr_req=1 in RUN:
  - The current-cycle grant still completes.
  - The next state is INIT with clr_cnt=0.
  - clr_req is ignored in INIT.

## Timing
- While rst=0: state=INIT, clr_cnt=0, b_starved=0.
- Outputs during reset: a_gnt=0, b_gnt=0, rf_write_signal=0 (gated by rst), rf_write_reg=0, rf_write_data=0, init_busy=1.
- Clear sequence:
  - First clear write (reg 0) commits at the first rising edge after rst deasserts.
  - Reg 31 commits at the 32nd edge.
  - init_busy falls after the 32nd edge; the first grant is possible in cycle 33.
- Grant-to-write latency: 0 cycles. gnt and the write enable are in the same cycle, and the data is in the register file after that edge.
- Reset asserted mid-INIT or mid-RUN: immediate return to reset values. A pending uncommitted write is lost. Clearing restarts from reg 0.
- Soft clear: 32 cycles of init_busy, starting the cycle after clr_req.

## Structure
- Shared package regfile_pkg:
  - ADDR_W, DATA_W, NREGS constants
  - rfc_state_t enum {INIT, RUN}
  - Reused by the register file and the writeback stage.
- The two-input starvation-guarded arbiter is a natural sub-module, wb_arbiter2. Its inputs are a_req, b_req and b_starved; its outputs are a_gnt and b_gnt.
- The clear counter and FSM stay in the top module.

## Test plan
- Release rst, no requests:
  - rf_write_signal=1 for exactly 32 cycles with rf_write_reg 0..31 and data 0.
  - init_busy drops after edge 32.
  - Readback of all registers = 0x00000000.
- RUN, a_req with a_addr=5, a_data=0xDEADBEEF: a_gnt=1 the same cycle; register 5 = 0xDEADBEEF after the edge.
- a_req and b_req held together for 6 cycles with distinct addresses: grant sequence A,B,A,B,A,B; b_gnt never low for two consecutive requesting cycles.
- a_req with a_addr=0, a_data=0x12345678: a_gnt=1, rf_write_signal=0, register 0 stays 0.
- Both request rd=7, A data 0x11, B data 0x22: A granted first, B next; register 7 = 0x22.
- clr_req pulse during RUN, and separately rst pulsed at INIT cycle 10:
  - init_busy=1 for 32 cycles; all registers zero afterwards.
  - After the rst pulse, clearing restarts at rf_write_reg=0.
